// File: rtl/rcon_sequencer.sv
// Rcon / word-schedule sequencer for AES key expansion.
// Walks the expanded-key word index forward (expansion) or backward
// (on-the-fly decryption key regeneration). Rcon is produced iteratively
// in GF(2^8), and each word goes out on a valid/ready handshake.
//
// state  | meaning
// -------+-----------------------------------------------------------
// S_IDLE | waiting for start; outputs all zero
// S_RUN  | presenting word_idx / rcon / flags, stepping on handshake
// S_DONE | one-cycle done pulse after the final handshake
module rcon_sequencer #(
   parameter int NK    = 4,
   parameter int IDX_W = 6
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             dir,
   input  logic             abort,
   input  logic             out_ready,
   output logic             out_valid,
   output logic [IDX_W-1:0] word_idx,
   output logic [31:0]      rcon_word,
   output logic             rot_sub,
   output logic             sub_only,
   output logic             last,
   output logic             busy,
   output logic             done
);

   localparam int TOTAL = 4 * NK + 28;
   localparam int I_LO  = NK;
   localparam int I_HI  = TOTAL - 1;
   localparam int PH_HI = I_HI % NK;
   localparam logic [7:0] RC_FINAL = (NK == 4) ? 8'h36 : (NK == 6) ? 8'h80 : 8'h40;

   generate
      if (!(NK == 4 || NK == 6 || NK == 8)) begin : g_bad_nk
         $error("rcon_sequencer: NK must be 4, 6 or 8");
      end
      if (TOTAL > (1 << IDX_W)) begin : g_bad_idx_w
         $error("rcon_sequencer: IDX_W too narrow for the word index");
      end
   endgenerate

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           state_q;
   state_t           state_d;
   logic             dir_q;
   logic [IDX_W-1:0] idx_q;
   logic [2:0]       ph_q;
   logic [7:0]       rcon_q;

   logic run;
   logic hs;
   logic is_rot;
   logic is_sub;
   logic is_last;
   logic launch;

   assign run     = (state_q == S_RUN);
   assign hs      = run && out_ready;
   assign launch  = (state_q == S_IDLE) && start && !abort;
   // ph_q tracks idx mod NK, so no divider is needed for the qualifiers
   assign is_rot  = (ph_q == 3'd0);
   assign is_sub  = (NK == 8) && (ph_q == 3'd4);
   assign is_last = (idx_q == (dir_q ? IDX_W'(I_LO) : IDX_W'(I_HI)));

   // state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   // next-state logic; abort has priority over a same-cycle handshake
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: if (launch) state_d = S_RUN;
         S_RUN: begin
            if (abort)              state_d = S_IDLE;
            else if (hs && is_last) state_d = S_DONE;
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // index, phase and Rcon datapath; cleared whenever a run ends
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dir_q  <= 1'b0;
         idx_q  <= '0;
         ph_q   <= 3'd0;
         rcon_q <= 8'h01;
      end else if (launch) begin
         dir_q  <= dir;
         idx_q  <= dir ? IDX_W'(I_HI) : IDX_W'(I_LO);
         ph_q   <= dir ? 3'(PH_HI) : 3'd0;
         rcon_q <= dir ? RC_FINAL : 8'h01;
      end else if (run && (abort || (hs && is_last))) begin
         dir_q  <= 1'b0;
         idx_q  <= '0;
         ph_q   <= 3'd0;
         rcon_q <= 8'h01;
      end else if (hs) begin
         if (!dir_q) begin
            idx_q <= idx_q + 1'b1;
            ph_q  <= (ph_q == 3'(NK - 1)) ? 3'd0 : ph_q + 3'd1;
            if (is_rot)
               rcon_q <= {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
         end else begin
            idx_q <= idx_q - 1'b1;
            ph_q  <= (ph_q == 3'd0) ? 3'(NK - 1) : ph_q - 3'd1;
            if (is_rot)
               rcon_q <= {1'b0, rcon_q[7:1]} ^ (rcon_q[0] ? 8'h8d : 8'h00);
         end
      end
   end

   // outputs decode only registered state, so they hold while stalled
   always_comb begin
      out_valid = run;
      word_idx  = run ? idx_q : '0;
      rot_sub   = run && is_rot;
      sub_only  = run && is_sub;
      rcon_word = (run && is_rot) ? {rcon_q, 24'h0} : 32'h0;
      last      = run && is_last;
      busy      = run;
      done      = (state_q == S_DONE);
   end

endmodule

// File: tb/tb_rcon_sequencer.sv
// Bench for rcon_sequencer: three instances (NK = 4, 6, 8) share stimulus
// and are checked against a word-list reference model built from the
// key-schedule rules (index range, i mod NK, Rcon table).
module tb_rcon_sequencer;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic start = 1'b0;
   logic dir = 1'b0;
   logic abort = 1'b0;
   logic out_ready = 1'b0;

   logic        vld [3];
   logic [5:0]  widx[3];
   logic [31:0] rw  [3];
   logic        rs  [3];
   logic        so  [3];
   logic        lst [3];
   logic        bsy [3];
   logic        dn  [3];

   int pass_cnt = 0;
   int total = 0;
   int nk_tab[3] = '{4, 6, 8};
   logic [7:0] rc_tab[10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                              8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

   always #5 clk = ~clk;

   rcon_sequencer #(.NK(4), .IDX_W(6)) u_nk4 (
      .clk(clk), .rst_n(rst_n), .start(start), .dir(dir), .abort(abort),
      .out_ready(out_ready), .out_valid(vld[0]), .word_idx(widx[0]),
      .rcon_word(rw[0]), .rot_sub(rs[0]), .sub_only(so[0]), .last(lst[0]),
      .busy(bsy[0]), .done(dn[0]));

   rcon_sequencer #(.NK(6), .IDX_W(6)) u_nk6 (
      .clk(clk), .rst_n(rst_n), .start(start), .dir(dir), .abort(abort),
      .out_ready(out_ready), .out_valid(vld[1]), .word_idx(widx[1]),
      .rcon_word(rw[1]), .rot_sub(rs[1]), .sub_only(so[1]), .last(lst[1]),
      .busy(bsy[1]), .done(dn[1]));

   rcon_sequencer #(.NK(8), .IDX_W(6)) u_nk8 (
      .clk(clk), .rst_n(rst_n), .start(start), .dir(dir), .abort(abort),
      .out_ready(out_ready), .out_valid(vld[2]), .word_idx(widx[2]),
      .rcon_word(rw[2]), .rot_sub(rs[2]), .sub_only(so[2]), .last(lst[2]),
      .busy(bsy[2]), .done(dn[2]));

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) pass_cnt++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   function automatic logic [31:0] exp_rcon(input int nk, input int i);
      if (i % nk != 0) return 32'h0;
      return {rc_tab[i / nk - 1], 24'h0};
   endfunction

   task automatic check_idle(input string tag);
      for (int k = 0; k < 3; k++)
         chk($sformatf("%s_nk%0d", tag, nk_tab[k]),
             {vld[k], bsy[k], dn[k], rs[k], so[k], lst[k], widx[k], rw[k]}, 64'h0);
   endtask

   // One sequence on all three instances. Optional events keyed on the
   // NK=4 instance's expected index: hold (3 stall cycles), abort, reset.
   task automatic run_seq(input bit d, input int ready_pct, input int hold_idx,
                          input int abort_idx, input int rst_idx, input int mid_start);
      int pos[3];
      int fin[3];
      int holds;
      int cyc;
      int e0;
      bit stop;
      bit do_abort;
      bit do_rst;
      holds = 0;
      cyc = 0;
      stop = 1'b0;
      for (int k = 0; k < 3; k++) begin
         pos[k] = 0;
         fin[k] = 0;
      end
      @(negedge clk);
      start = 1'b1;
      dir = d;
      abort = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      while (!stop) begin
         start = 1'b0;
         abort = 1'b0;
         do_abort = 1'b0;
         do_rst = 1'b0;
         out_ready = ($urandom_range(99) < ready_pct);
         e0 = d ? (43 - pos[0]) : (4 + pos[0]);
         if (fin[0] == 0 && e0 == hold_idx && holds < 3) begin
            out_ready = 1'b0;
            holds++;
         end
         if (fin[0] == 0 && e0 == abort_idx) begin
            abort = 1'b1;
            out_ready = 1'b1;
            do_abort = 1'b1;
         end
         if (fin[0] == 0 && e0 == rst_idx) do_rst = 1'b1;
         if (cyc == mid_start) begin
            start = 1'b1;
            dir = ~d;
         end
         if (fin[0] == 1) start = 1'b1;
         for (int k = 0; k < 3; k++) begin
            int nk;
            int lo;
            int hi;
            int i;
            int i_end;
            string t;
            nk = nk_tab[k];
            lo = nk;
            hi = 4 * nk + 27;
            i = d ? (hi - pos[k]) : (lo + pos[k]);
            i_end = d ? lo : hi;
            t = $sformatf("nk%0d_d%0d", nk, d);
            if (fin[k] == 0) begin
               chk({t, "_valid"}, vld[k], 1'b1);
               chk({t, "_busy"}, bsy[k], 1'b1);
               chk({t, "_done"}, dn[k], 1'b0);
               chk({t, "_idx"}, widx[k], i);
               chk({t, "_rcon"}, rw[k], exp_rcon(nk, i));
               chk({t, "_rot_sub"}, rs[k], (i % nk) == 0);
               chk({t, "_sub_only"}, so[k], (nk == 8) && ((i % 8) == 4));
               chk({t, "_last"}, lst[k], i == i_end);
               if (out_ready && !abort) begin
                  if (i == i_end) fin[k] = 1;
                  else pos[k]++;
               end
            end else if (fin[k] == 1) begin
               chk({t, "_done_pulse"}, {dn[k], vld[k], bsy[k]}, 3'b100);
               fin[k] = 2;
            end else begin
               chk({t, "_after_done"}, {dn[k], vld[k], bsy[k]}, 3'b000);
            end
         end
         if (do_abort) begin
            @(negedge clk);
            abort = 1'b0;
            check_idle("abort_idle");
            stop = 1'b1;
         end else if (do_rst) begin
            rst_n = 1'b0;
            #1;
            check_idle("async_reset");
            @(negedge clk);
            rst_n = 1'b1;
            @(negedge clk);
            check_idle("post_reset");
            stop = 1'b1;
         end else if (fin[0] == 2 && fin[1] == 2 && fin[2] == 2) begin
            stop = 1'b1;
         end else begin
            cyc++;
            if (cyc > 400) begin
               chk("cycle_budget", cyc, 400);
               stop = 1'b1;
            end
            @(negedge clk);
         end
      end
      start = 1'b0;
      abort = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check_idle("reset");
      rst_n = 1'b1;
      @(negedge clk);
      check_idle("idle");

      start = 1'b1;
      abort = 1'b1;
      @(negedge clk);
      start = 1'b0;
      abort = 1'b0;
      check_idle("start_abort");
      @(negedge clk);
      check_idle("start_abort_2");

      run_seq(1'b0, 100, -1, -1, -1, -1);
      run_seq(1'b1, 100, -1, -1, -1, -1);
      run_seq(1'b0, 100, 8, -1, -1, 10);
      run_seq(1'b0, 100, -1, 20, -1, 5);
      run_seq(1'b0, 60, -1, -1, -1, -1);
      run_seq(1'b1, 50, 40, -1, -1, 7);
      run_seq(1'b0, 70, -1, -1, 30, -1);
      run_seq(1'b0, 100, -1, -1, -1, -1);
      run_seq(1'b1, 65, -1, 25, -1, -1);
      run_seq(1'b1, 80, -1, -1, -1, -1);

      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end

endmodule
